// File: rtl/shift_pkg.sv
// Shared constants, op encodings and FSM states for the shift arbiter and its shift unit.
package shift_pkg;

  localparam int DATA_W  = 16;
  localparam int SHAMT_W = 4;
  localparam int NUM_REQ = 2;

  localparam logic [1:0] OP_SLL  = 2'b00;
  localparam logic [1:0] OP_SRA  = 2'b01;
  localparam logic [1:0] OP_ROR  = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_FULL = 1'b1
  } state_e;

endpackage

// File: rtl/shift_unit.sv
// Combinational 16-bit log shifter: four 2:1 mux stages of 1/2/4/8 for SLL, SRA and ROR.
module shift_unit
  import shift_pkg::*;
(
  input  logic [DATA_W-1:0]  in_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  input  logic [1:0]         op_i,
  output logic [DATA_W-1:0]  out_o
);

  for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
    localparam int N = 1 << k;
    logic [DATA_W-1:0] cur;
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] nxt;

    if (k == 0) begin : g_first
      assign cur = in_i;
    end else begin : g_chain
      assign cur = g_stage[k-1].nxt;
    end

    // Reserved op passes the operand through untouched.
    always_comb begin
      case (op_i)
        OP_SLL:  shifted = {cur[DATA_W-1-N:0], {N{1'b0}}};
        OP_SRA:  shifted = {{N{cur[DATA_W-1]}}, cur[DATA_W-1:N]};
        OP_ROR:  shifted = {cur[N-1:0], cur[DATA_W-1:N]};
        default: shifted = cur;
      endcase
    end

    assign nxt = shamt_i[k] ? shifted : cur;
  end

  assign out_o = g_stage[SHAMT_W-1].nxt;

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one shift unit between two requesters, with a
// single registered valid/ready response slot that supports back-to-back issue.
module shift_arbiter
  import shift_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  input  logic [NUM_REQ*SHAMT_W-1:0] req_shamt,
  input  logic [NUM_REQ*2-1:0]       req_op,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [DATA_W-1:0]          rsp_data,
  output logic                       rsp_id
);

  state_e              state_q, state_d;
  logic                rr_ptr_q, rr_ptr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                id_q, id_d;

  logic [NUM_REQ-1:0]  grant;
  logic                can_accept;
  logic                sel;
  logic                xfer;
  logic [DATA_W-1:0]   sh_in, sh_out;
  logic [SHAMT_W-1:0]  sh_amt;
  logic [1:0]          sh_op;

  assign can_accept = (state_q == S_IDLE) | rsp_ready;

  always_comb begin
    case (req_valid)
      2'b11:   grant = rr_ptr_q ? 2'b10 : 2'b01;
      default: grant = req_valid;
    endcase
  end

  // Gating with rst_n keeps req_ready low while reset is held.
  assign req_ready = (rst_n & can_accept) ? grant : 2'b00;
  assign xfer      = |(req_valid & req_ready);
  assign sel       = grant[1];

  assign sh_in  = sel ? req_data[2*DATA_W-1:DATA_W]    : req_data[DATA_W-1:0];
  assign sh_amt = sel ? req_shamt[2*SHAMT_W-1:SHAMT_W] : req_shamt[SHAMT_W-1:0];
  assign sh_op  = sel ? req_op[3:2]                    : req_op[1:0];

  shift_unit u_shift_unit (
    .in_i    (sh_in),
    .shamt_i (sh_amt),
    .op_i    (sh_op),
    .out_o   (sh_out)
  );

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    data_d   = data_q;
    id_d     = id_q;
    if (xfer) begin
      state_d  = S_FULL;
      data_d   = sh_out;
      id_d     = sel;
      rr_ptr_d = ~sel;
    end else if ((state_q == S_FULL) && rsp_ready) begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= 1'b0;
      data_q   <= '0;
      id_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      data_q   <= data_d;
      id_q     <= id_d;
    end
  end

  assign rsp_valid = (state_q == S_FULL);
  assign rsp_data  = data_q;
  assign rsp_id    = id_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Scoreboard bench for shift_arbiter: a cycle-level arbitration model pushes expected
// results; a separate monitor pops and compares them as responses are presented.
module tb_shift_arbiter;
  import shift_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req_data;
  logic [7:0]  req_shamt;
  logic [3:0]  req_op;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic        rsp_id;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        id;
    logic [15:0] data;
  } exp_t;

  exp_t exp_q[$];
  logic ptr_m  = 1'b0;
  logic full_m = 1'b0;

  always #5 clk = ~clk;

  shift_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .req_shamt (req_shamt),
    .req_op    (req_op),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id)
  );

  function automatic logic [15:0] ref_shift(input logic [15:0] d, input int s, input logic [1:0] op);
    logic [31:0] w;
    int          sv;
    case (op)
      2'b00: begin w = {16'h0000, d} << s; return w[15:0]; end
      2'b01: begin sv = int'($signed(d)); sv = sv >>> s; return sv[15:0]; end
      2'b10: begin w = {d, d} >> s; return w[15:0]; end
      default: return d;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Arbitration model: decides who should be accepted this cycle and predicts the result.
  always @(negedge clk) begin
    logic       can;
    logic [1:0] g;
    logic       id;
    if (!rst_n) begin
      ptr_m  = 1'b0;
      full_m = 1'b0;
    end else begin
      check("rsp_valid", {31'd0, rsp_valid}, {31'd0, full_m});
      can = !full_m || rsp_ready;
      g = 2'b00;
      if (req_valid == 2'b11) g[ptr_m] = 1'b1;
      else                    g = req_valid;
      if (!can) g = 2'b00;
      check("req_ready", {30'd0, req_ready}, {30'd0, g});
      if (g != 2'b00) begin
        id = g[1];
        exp_q.push_back({id, ref_shift(req_data[16*id +: 16], int'(req_shamt[4*id +: 4]), req_op[2*id +: 2])});
        ptr_m  = ~id;
        full_m = 1'b1;
      end else if (rsp_ready) begin
        full_m = 1'b0;
      end
    end
  end

  // Response monitor.
  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_extra: got id %0d data %h expected no response", rsp_id, rsp_data);
      end else begin
        check("rsp_id", {31'd0, rsp_id}, {31'd0, exp_q[0].id});
        check("rsp_data", {16'd0, rsp_data}, {16'd0, exp_q[0].data});
        if (rsp_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid = 2'b00;
    req_data  = '0;
    req_shamt = '0;
    req_op    = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic single(input int id, input logic [15:0] d, input logic [3:0] s,
                        input logic [1:0] op, input logic [15:0] exp, input string name);
    idle_inputs();
    req_valid[id]         = 1'b1;
    req_data[16*id +: 16] = d;
    req_shamt[4*id +: 4]  = s;
    req_op[2*id +: 2]     = op;
    rsp_ready = 1'b1;
    cyc();
    req_valid = 2'b00;
    check({name, "_valid"}, {31'd0, rsp_valid}, 32'd1);
    check({name, "_data"}, {16'd0, rsp_data}, {16'd0, exp});
    check({name, "_id"}, {31'd0, rsp_id}, id);
  endtask

  logic [15:0] held_data;

  initial begin
    idle_inputs();
    rsp_ready = 1'b0;
    rst_n     = 1'b0;
    #2;
    req_valid = 2'b11;
    #1;
    check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("reset_rsp_data", {16'd0, rsp_data}, 32'd0);
    check("reset_rsp_id", {31'd0, rsp_id}, 32'd0);
    check("reset_req_ready", {30'd0, req_ready}, 32'd0);
    idle_inputs();
    do_reset();

    // Single ROR and shift corners.
    single(0, 16'h1234, 4'd4,  OP_ROR,  16'h4123, "ror0");
    single(1, 16'h8000, 4'd15, OP_SRA,  16'hFFFF, "sra15");
    single(1, 16'h0001, 4'd15, OP_SLL,  16'h8000, "sll15");
    single(0, 16'hA5C3, 4'd0,  OP_SLL,  16'hA5C3, "sll0");
    single(1, 16'hA5C3, 4'd0,  OP_SRA,  16'hA5C3, "sra0");
    single(0, 16'hA5C3, 4'd0,  OP_ROR,  16'hA5C3, "ror0s");
    single(1, 16'hA5C3, 4'd7,  OP_RSVD, 16'hA5C3, "rsvd");
    single(0, 16'h7F00, 4'd9,  OP_SRA,  16'h003F, "sra_pos");

    // Contention after reset: strict alternation, no bubbles.
    rsp_ready = 1'b1;
    idle_inputs();
    do_reset();
    req_valid = 2'b11;
    req_data  = {16'hBEEF, 16'h1357};
    req_shamt = {4'd3, 4'd5};
    req_op    = {OP_SLL, OP_ROR};
    for (int i = 0; i < 6; i++) begin
      cyc();
      check("alt_valid", {31'd0, rsp_valid}, 32'd1);
      check("alt_id", {31'd0, rsp_id}, i % 2);
    end

    // Backpressure, then simultaneous retire + load.
    idle_inputs();
    rsp_ready = 1'b1;
    cyc();
    req_valid = 2'b01;
    req_data  = {16'h0F0F, 16'hC001};
    req_shamt = {4'd2, 4'd1};
    req_op    = {OP_SRA, OP_SLL};
    rsp_ready = 1'b0;
    cyc();
    held_data = rsp_data;
    req_valid = 2'b10;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("stall_ready", {30'd0, req_ready}, 32'd0);
      check("stall_data", {16'd0, rsp_data}, {16'd0, held_data});
      check("stall_id", {31'd0, rsp_id}, 32'd0);
    end
    rsp_ready = 1'b1;
    #1;
    check("b2b_ready", {30'd0, req_ready}, 32'd2);
    cyc();
    req_valid = 2'b00;
    check("b2b_valid", {31'd0, rsp_valid}, 32'd1);
    check("b2b_id", {31'd0, rsp_id}, 32'd1);
    check("b2b_data", {16'd0, rsp_data}, 32'h03C3);

    // Asynchronous reset while holding a result.
    req_valid = 2'b10;
    rsp_ready = 1'b0;
    cyc();
    req_valid = 2'b11;
    #2 rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("async_rst_valid", {31'd0, rsp_valid}, 32'd0);
    check("async_rst_ready", {30'd0, req_ready}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    rsp_ready = 1'b1;
    #1;
    check("post_rst_grant", {30'd0, req_ready}, 32'd1);
    cyc();
    check("post_rst_id", {31'd0, rsp_id}, 32'd0);

    // Random soak.
    for (int i = 0; i < 10000; i++) begin
      req_valid = 2'($urandom);
      req_data  = $urandom;
      req_shamt = 8'($urandom);
      req_op    = 4'($urandom);
      rsp_ready = ($urandom % 4) != 0;
      cyc();
    end

    idle_inputs();
    rsp_ready = 1'b1;
    repeat (3) cyc();
    check("drain_empty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
